// File: rtl/viterbi_traceback.sv
// Block traceback unit for an 8-state (K=4) Viterbi decoder: stores one frame of ACS
// decision vectors, traces back from a supplied end state and streams the bits out in time order.
module viterbi_traceback #(
    parameter int TB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dec_in,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [2:0] start_state,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       frame_done
);

    localparam int PW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(TB_DEPTH - 1);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_TRACE  = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tb_ptr_q, tb_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    cur_state_q, cur_state_d;
    logic          frame_done_q, frame_done_d;

    logic [7:0] mem_q  [TB_DEPTH];
    logic       obuf_q [TB_DEPTH];

    logic dec_fire;
    logic bit_fire;
    logic sel;

    // The frame_done cycle still belongs to the finished frame, so FILL opens one cycle later.
    assign dec_ready  = (state_q == S_FILL) && !frame_done_q;
    assign bit_valid  = (state_q == S_OUTPUT);
    assign bit_out    = bit_valid & obuf_q[rd_ptr_q];
    assign frame_done = frame_done_q;

    assign dec_fire = dec_valid && dec_ready;
    assign bit_fire = bit_valid && bit_ready;
    assign sel      = mem_q[tb_ptr_q][cur_state_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tb_ptr_d     = tb_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cur_state_d  = cur_state_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (dec_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        cur_state_d = start_state;
                        tb_ptr_d    = LAST_IDX;
                        wr_ptr_d    = '0;
                        state_d     = S_TRACE;
                    end
                end
            end
            S_TRACE: begin
                // Step to the surviving predecessor: the selection bit becomes the new MSB.
                cur_state_d = {sel, cur_state_q[2:1]};
                tb_ptr_d    = tb_ptr_q - 1'b1;
                if (tb_ptr_q == '0) begin
                    state_d  = S_OUTPUT;
                    rd_ptr_d = '0;
                end
            end
            S_OUTPUT: begin
                if (bit_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d     = '0;
                        frame_done_d = 1'b1;
                        state_d      = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            tb_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cur_state_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            tb_ptr_q     <= tb_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cur_state_q  <= cur_state_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage arrays carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (dec_fire) begin
            mem_q[wr_ptr_q] <= dec_in;
        end
        if (state_q == S_TRACE) begin
            obuf_q[tb_ptr_q] <= cur_state_q[0];
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomised scoreboard bench for viterbi_traceback: a traceback reference model fills an
// expected-bit queue at stimulus time and an independent monitor checks every output handshake.
module tb_viterbi_traceback;

    localparam int D = 16;
    typedef logic [7:0] frame_t [D];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dec_in;
    logic       dec_valid;
    logic       dec_ready;
    logic [2:0] start_state;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       frame_done;

    viterbi_traceback #(.TB_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_in     (dec_in),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .start_state(start_state),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int frames_expected = 0;
    int rdy_mode = 0;
    bit exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference traceback: walk the trellis backwards from the end state, recording n[0]
    // at each step and moving to predecessor (selection * 4 + n / 2).
    task automatic push_expected(input frame_t v, input int st);
        int bits [D];
        int s;
        s = st;
        for (int t = D - 1; t >= 0; t--) begin
            bits[t] = s % 2;
            s = ((int'(v[t]) >> s) % 2) * 4 + s / 2;
        end
        for (int t = 0; t < D; t++) exp_q.push_back(bits[t] != 0);
        frames_expected++;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the final vector was accepted.
    task automatic send_frame(input frame_t v, input int st, input bit push,
                              input bit gaps, input bit measure);
        int waited;
        int n;
        int lat;
        if (push) push_expected(v, st);
        for (int i = 0; i < D; i++) begin
            if (gaps) begin
                dec_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            dec_valid   = 1'b1;
            dec_in      = v[i];
            start_state = (i == D - 1) ? 3'(st) : 3'($urandom_range(0, 7));
            waited = 0;
            forever begin
                @(negedge clk);
                if (dec_ready) break;
                waited++;
                if (waited > 500) break;
            end
            if (waited > 500) begin
                check("accept_timeout", waited, 0);
                dec_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (!measure) begin
            dec_valid = 1'b0;
            return;
        end
        // Keep offering junk vectors; none may be taken until the next FILL opens.
        n = 0;
        lat = 0;
        dec_in = 8'($urandom);
        forever begin
            @(negedge clk);
            n++;
            if (bit_valid && lat == 0) lat = n;
            if (dec_ready || n > 1000) break;
            @(posedge clk); #1;
            dec_in = 8'($urandom);
        end
        dec_valid = 1'b0;
        check("ready_low_cycles", n - 1, 2 * D + 1);
        check("first_valid_latency", lat, D + 1);
        @(posedge clk); #1;
    endtask

    // bit_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    initial begin
        int phase;
        phase = 0;
        bit_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bit_ready = 1'b1;
                1: begin bit_ready = (phase == 0); phase = (phase + 1) % 3; end
                default: bit_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every accepted bit against the scoreboard and checks stall stability.
    initial begin
        bit stall_pend;
        bit stall_bit;
        int frame_bits;
        bit e;
        stall_pend = 1'b0;
        stall_bit  = 1'b0;
        frame_bits = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
                frame_bits = 0;
            end else begin
                if (stall_pend) begin
                    check("stall_valid", int'(bit_valid), 1);
                    check("stall_bit", int'(bit_out), int'(stall_bit));
                end
                if (frame_done) begin
                    done_count++;
                    check("frame_done_bits", frame_bits, D);
                    frame_bits = 0;
                end
                if (bit_valid && exp_q.size() == 0) begin
                    check("unexpected_valid", int'(bit_valid), 0);
                    stall_pend = 1'b0;
                end else if (bit_valid && bit_ready) begin
                    e = exp_q.pop_front();
                    check("bit", int'(bit_out), int'(e));
                    frame_bits++;
                    stall_pend = 1'b0;
                end else if (bit_valid) begin
                    stall_pend = 1'b1;
                    stall_bit  = bit_out;
                end else begin
                    stall_pend = 1'b0;
                    if (bit_out) check("bit_out_idle", int'(bit_out), 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dec_ready"}, int'(dec_ready), 1);
        check({tag, "_bit_valid"}, int'(bit_valid), 0);
        check({tag, "_bit_out"}, int'(bit_out), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        frame_t v;
        int st;
        int waited;
        rst_n       = 1'b0;
        dec_valid   = 1'b0;
        dec_in      = 8'h00;
        start_state = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_ready", int'(dec_ready), 1);
        @(posedge clk); #1;

        // All-zero frame, start 0
        rdy_mode = 0;
        for (int i = 0; i < D; i++) v[i] = 8'h00;
        send_frame(v, 0, 1'b1, 1'b0, 1'b0);
        // All-ones frame, start 7
        for (int i = 0; i < D; i++) v[i] = 8'hFF;
        send_frame(v, 7, 1'b1, 1'b0, 1'b0);
        // All-zero frame, start 5
        for (int i = 0; i < D; i++) v[i] = 8'h00;
        send_frame(v, 5, 1'b1, 1'b0, 1'b0);
        // Same, with backpressure pattern 1,0,0
        send_frame(v, 5, 1'b1, 1'b0, 1'b0);
        rdy_mode = 1;
        waited = 0;
        while (exp_q.size() > 0 && waited < 3000) begin @(posedge clk); #1; waited++; end
        rdy_mode = 0;

        // Flow control: dec_valid held high across two random frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < D; i++) v[i] = 8'($urandom);
            send_frame(v, $urandom_range(0, 7), 1'b1, 1'b0, 1'b1);
        end

        // Reset during trace step 7, then a fresh all-zero frame
        for (int i = 0; i < D; i++) v[i] = 8'($urandom);
        send_frame(v, 3, 1'b0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_ready_after", int'(dec_ready), 1);
        @(posedge clk); #1;
        for (int i = 0; i < D; i++) v[i] = 8'h00;
        send_frame(v, 0, 1'b1, 1'b0, 1'b0);

        // Random frames with random gaps and random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < D; i++) v[i] = 8'($urandom);
            st = $urandom_range(0, 7);
            send_frame(v, st, 1'b1, 1'b1, 1'b0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 5000) begin @(posedge clk); #1; waited++; end
        repeat (4) @(posedge clk);
        #1;
        check("drain_queue_left", exp_q.size(), 0);
        check("frame_done_count", done_count, frames_expected);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
